led7seg_scan_mux: RTL and testbench

//  Downstream display stage for the traffic-light controller. Takes the four

---
 rtl/led7seg_scan_mux.sv | 117 +++++++++++
 tb/tb_led7seg_scan_mux.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/led7seg_scan_mux.sv
// Time-multiplexes four static 7-seg patterns onto one shared segment bus with
// dead-time blanking, 3-bit PWM brightness and tear-free per-frame snapshots.
module led7seg_scan_mux #(
    parameter int REFRESH_DIV  = 20000,
    parameter int BLANK_CYCLES = 200
) (
    input  logic       clk20M,
    input  logic       Reset,
    input  logic       enable,
    input  logic [6:0] hex0,
    input  logic [6:0] hex1,
    input  logic [6:0] hex2,
    input  logic [6:0] hex3,
    input  logic [2:0] brightness,
    output logic [6:0] seg,
    output logic [3:0] dig,
    output logic       frame_tick
);

    localparam logic [1:0] S_OFF   = 2'd0;
    localparam logic [1:0] S_BLANK = 2'd1;
    localparam logic [1:0] S_DRIVE = 2'd2;
    localparam logic [1:0] S_DARK  = 2'd3;

    localparam logic [15:0] P_LAST  = 16'(REFRESH_DIV - 1);
    localparam logic [15:0] P_BLANK = 16'(BLANK_CYCLES);
    localparam logic [15:0] P_UNIT  = 16'((REFRESH_DIV - BLANK_CYCLES) >> 3);

    logic [1:0]      r_state;
    logic [15:0]     r_pos;
    logic [1:0]      r_idx;
    logic [2:0]      r_bright_q;
    logic [6:0]      r_seg;
    logic [3:0]      r_dig;
    logic            r_frame_tick;

    logic [3:0][6:0] w_hex;
    logic [3:0][6:0] w_snap_eff;
    logic            w_frame_start;
    logic            w_slot_end;
    logic [2:0]      w_bright_eff;
    logic [3:0]      w_bright_p1;
    logic [15:0]     w_on_len;
    logic [15:0]     w_pos_next;
    logic [1:0]      w_cur_phase;
    logic [1:0]      w_state_next;

    function automatic logic [1:0] f_phase(input logic [15:0] p, input logic [15:0] len);
        if (p < P_BLANK)
            return S_BLANK;
        else if (p < P_BLANK + len)
            return S_DRIVE;
        else
            return S_DARK;
    endfunction

    assign w_hex         = {hex3, hex2, hex1, hex0};
    assign w_frame_start = enable && (r_pos == 16'd0) && (r_idx == 2'd0);
    assign w_slot_end    = (r_pos == P_LAST);

    // During the snapshot cycle the live inputs stand in for the not-yet-loaded snapshot.
    assign w_bright_eff  = w_frame_start ? brightness : r_bright_q;
    assign w_bright_p1   = {1'b0, w_bright_eff} + 4'd1;
    assign w_on_len      = P_UNIT * {12'd0, w_bright_p1};
    assign w_pos_next    = w_slot_end ? 16'd0 : r_pos + 16'd1;
    assign w_cur_phase   = (r_state == S_OFF) ? f_phase(16'd0, w_on_len) : r_state;
    assign w_state_next  = f_phase(w_pos_next, w_on_len);

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_snap
            logic [6:0] r_snap;
            always_ff @(posedge clk20M) begin
                if (Reset)
                    r_snap <= 7'h7F;
                else if (w_frame_start)
                    r_snap <= w_hex[gi];
            end
            assign w_snap_eff[gi] = w_frame_start ? w_hex[gi] : r_snap;
        end
    endgenerate

    always_ff @(posedge clk20M) begin
        if (Reset)
            r_bright_q <= 3'd0;
        else if (w_frame_start)
            r_bright_q <= brightness;
    end

    always_ff @(posedge clk20M) begin
        if (Reset || !enable) begin
            r_state      <= S_OFF;
            r_pos        <= 16'd0;
            r_idx        <= 2'd0;
            r_dig        <= 4'hF;
            r_seg        <= 7'h7F;
            r_frame_tick <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_pos        <= w_pos_next;
            r_idx        <= w_slot_end ? r_idx + 2'd1 : r_idx;
            r_frame_tick <= w_frame_start;
            if (w_cur_phase == S_DRIVE) begin
                r_dig <= ~(4'b0001 << r_idx);
                r_seg <= w_snap_eff[r_idx];
            end else begin
                r_dig <= 4'hF;
                r_seg <= 7'h7F;
            end
        end
    end

    assign seg        = r_seg;
    assign dig        = r_dig;
    assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_led7seg_scan_mux.sv
// Cycle-level bench for led7seg_scan_mux: a frame-time reference model predicts
// every output cycle under directed and randomized stimulus.
module tb_led7seg_scan_mux;

    localparam int D     = 40;
    localparam int B     = 8;
    localparam int FRAME = 4 * D;

    logic       clk20M = 1'b0;
    logic       Reset  = 1'b1;
    logic       enable = 1'b0;
    logic [6:0] hex0 = 7'h7F, hex1 = 7'h7F, hex2 = 7'h7F, hex3 = 7'h7F;
    logic [2:0] brightness = 3'd0;
    logic [6:0] seg;
    logic [3:0] dig;
    logic       frame_tick;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_frames = 0;

    // Model: cycles since the current frame began, plus the frame's snapshot.
    int         m_t  = 0;
    int         m_bq = 0;
    logic [6:0] m_snap [4];

    led7seg_scan_mux #(.REFRESH_DIV(D), .BLANK_CYCLES(B)) dut (
        .clk20M     (clk20M),
        .Reset      (Reset),
        .enable     (enable),
        .hex0       (hex0),
        .hex1       (hex1),
        .hex2       (hex2),
        .hex3       (hex3),
        .brightness (brightness),
        .seg        (seg),
        .dig        (dig),
        .frame_tick (frame_tick)
    );

    always #5 clk20M = ~clk20M;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        logic [3:0] e_dig;
        logic [6:0] e_seg;
        logic       e_tick;
        int         pos;
        int         idx;
        logic [6:0] cur_hex [4];
        cur_hex = '{hex0, hex1, hex2, hex3};
        e_dig  = 4'hF;
        e_seg  = 7'h7F;
        e_tick = 1'b0;
        if (Reset) begin
            m_t  = 0;
            m_bq = 0;
            for (int i = 0; i < 4; i++) m_snap[i] = 7'h7F;
        end else if (!enable) begin
            m_t = 0;
        end else begin
            pos = m_t % D;
            idx = m_t / D;
            if (m_t == 0) begin
                e_tick = 1'b1;
                m_snap = cur_hex;
                m_bq   = int'(brightness);
                n_frames++;
                $display("frame %0d: hex=%h/%h/%h/%h bright=%0d on_len=%0d",
                         n_frames, cur_hex[0], cur_hex[1], cur_hex[2], cur_hex[3],
                         m_bq, 4 * (m_bq + 1));
            end
            if (pos >= B && pos < B + 4 * (m_bq + 1)) begin
                e_dig      = 4'hF;
                e_dig[idx] = 1'b0;
                e_seg      = m_snap[idx];
            end
            m_t = (m_t + 1) % FRAME;
        end
        @(posedge clk20M);
        #1;
        chk("dig", 32'(dig), 32'(e_dig));
        chk("seg", 32'(seg), 32'(e_seg));
        chk("frame_tick", 32'(frame_tick), 32'(e_tick));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        // Reset with enable held high, then the reference digit pattern at full brightness.
        Reset = 1'b1; enable = 1'b1; brightness = 3'd7;
        run(3);
        Reset = 1'b0;
        hex0 = 7'h40; hex1 = 7'h79; hex2 = 7'h24; hex3 = 7'h30;
        run(2 * FRAME);

        // Dimmest, then a mid-frame brightness change that must wait for the next frame.
        brightness = 3'd0;
        run(FRAME + 60);
        brightness = 3'd5;
        run(100 + FRAME);

        // hex1 changes while idx 0 is shown.
        run(10);
        hex1 = 7'h12;
        run(FRAME - 10 + FRAME);

        // enable drop during DRIVE of idx 2, then restart.
        run(90);
        enable = 1'b0;
        run(20);
        enable = 1'b1;
        run(FRAME);

        // Reset during DRIVE of idx 1.
        run(50);
        Reset = 1'b1;
        run(2);
        Reset = 1'b0;
        run(FRAME + 5);

        // Randomized inputs, enable drops and occasional resets.
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0) hex0 = 7'($urandom);
            if ($urandom_range(0, 19) == 0) hex1 = 7'($urandom);
            if ($urandom_range(0, 19) == 0) hex2 = 7'($urandom);
            if ($urandom_range(0, 19) == 0) hex3 = 7'($urandom);
            if ($urandom_range(0, 49) == 0) brightness = 3'($urandom);
            if (enable) begin
                if ($urandom_range(0, 299) == 0) enable = 1'b0;
            end else if ($urandom_range(0, 9) == 0) begin
                enable = 1'b1;
            end
            Reset = ($urandom_range(0, 599) == 0);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
